shk_sccb_wr: RTL

//  Byte-level SCCB/I2C write master, directly downstream of the shake command writer. Accepts one byte per

---
 rtl/shk_sccb_pkg.sv | 26 ++
 rtl/shk_qtr_tick.sv | 24 ++
 rtl/shk_sccb_wr.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/shk_sccb_pkg.sv
// Shared encodings for the shake-driven SCCB byte writer: FSM states, quarter
// indices within an SCL period, bit counter landmarks and error flag positions.
package shk_sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [1:0] QTR0 = 2'd0;
  localparam logic [1:0] QTR1 = 2'd1;
  localparam logic [1:0] QTR2 = 2'd2;
  localparam logic [1:0] QTR3 = 2'd3;

  // bit 8 is the ack slot; bit 7 is the last data bit driven
  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_ACK  = 4'd8;

  localparam int ERR_BUSY = 0;
  localparam int ERR_DUAL = 1;
  localparam int ERR_NACK = 2;

endpackage

// File: rtl/shk_qtr_tick.sv
// Quarter-SCL-period divider: one-cycle tick every NB_DIV clocks, restartable
// so each FSM state starts a fresh quarter.
module shk_qtr_tick #(
  parameter int NB_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (NB_DIV > 2) ? $clog2(NB_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(NB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/shk_sccb_wr.sv
// Byte-level SCCB write master fed by shake strobes (valid = address byte,
// msync = data byte). Ack sampling is enabled by defining SHK_SCCB_ACK_CHECK_EN.
module shk_sccb_wr
  import shk_sccb_pkg::*;
#(
  parameter int WD_SHK_DATA  = 8,
  parameter int WD_SHK_ADDR  = 8,
  parameter int NB_QTR_DIV   = 125,
  parameter int NB_STOP_IDLE = 8,
  parameter int WD_ERR_INFO  = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   s_shk_valid,
  input  logic                   s_shk_msync,
  input  logic [WD_SHK_DATA-1:0] s_shk_mdata,
  input  logic [WD_SHK_ADDR-1:0] s_shk_maddr,
  output logic                   s_shk_ready,
  output logic                   s_shk_ssync,
  output logic [WD_SHK_DATA-1:0] s_shk_sdata,
  output logic [WD_SHK_ADDR-1:0] s_shk_saddr,
  output logic                   o_sccb_scl,
  output logic                   o_sccb_sda_o,
  output logic                   o_sccb_sda_t,
  input  logic                   i_sccb_sda_i,
  output logic [WD_ERR_INFO-1:0] m_err_shk_info1
);

  localparam int IW = (NB_STOP_IDLE > 1) ? $clog2(NB_STOP_IDLE) : 1;

  state_e                 state, state_d;
  logic [1:0]             qtr, qtr_d;
  logic [3:0]             bit_idx, bit_d;
  logic [IW-1:0]          idle_cnt, idle_d;
  logic [WD_SHK_DATA-1:0] byte_q, byte_d, sh_q, sh_d, new_byte;
  logic                   scl_d, sda_o_d, sda_t_d, ready_d, ssync_d;
  logic [WD_SHK_DATA-1:0] sdata_d;
  logic [WD_SHK_ADDR-1:0] saddr_d;
  logic [WD_ERR_INFO-1:0] err_d;
  logic                   tick, strobe, dual, accept;

  assign strobe   = s_shk_valid | s_shk_msync;
  assign dual     = s_shk_valid & s_shk_msync;
  assign new_byte = s_shk_valid ? WD_SHK_DATA'(s_shk_maddr) : s_shk_mdata;

  shk_qtr_tick #(.NB_DIV(NB_QTR_DIV)) u_tick (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_resetn),
    .restart (state_d != state),
    .tick    (tick)
  );

`ifndef SHK_SCCB_ACK_CHECK_EN
  logic sda_in_unused;
  assign sda_in_unused = i_sccb_sda_i;
`endif

  always_comb begin
    state_d = state;
    qtr_d   = qtr;
    bit_d   = bit_idx;
    idle_d  = idle_cnt;
    byte_d  = byte_q;
    sh_d    = sh_q;
    scl_d   = o_sccb_scl;
    sda_o_d = o_sccb_sda_o;
    sda_t_d = o_sccb_sda_t;
    ready_d = s_shk_ready;
    ssync_d = s_shk_ssync;
    sdata_d = s_shk_sdata;
    saddr_d = s_shk_saddr;
    err_d   = m_err_shk_info1;
    accept  = 1'b0;

    unique case (state)
      ST_IDLE: if (strobe) begin
        accept  = 1'b1;
        state_d = ST_START;
        qtr_d   = QTR0;
        ready_d = 1'b0;
        ssync_d = 1'b1;
        scl_d   = 1'b1;
        sda_o_d = 1'b1;
        sda_t_d = 1'b0;
      end
      ST_START: if (tick) begin
        if (qtr == QTR0) begin
          qtr_d   = QTR1;
          sda_o_d = 1'b0;
        end else begin
          state_d = ST_BIT;
          qtr_d   = QTR0;
          bit_d   = '0;
          scl_d   = 1'b0;
          sda_o_d = sh_q[WD_SHK_DATA-1];
        end
      end
      ST_BIT: if (tick) begin
        unique case (qtr)
          QTR0: qtr_d = QTR1;
          QTR1: begin qtr_d = QTR2; scl_d = 1'b1; end
          QTR2: qtr_d = QTR3;
          QTR3: begin
            qtr_d = QTR0;
            scl_d = 1'b0;
            if (bit_idx == BIT_ACK) begin
              state_d = ST_HOLD;
              idle_d  = '0;
              ready_d = 1'b1;
              saddr_d = s_shk_saddr + 1'b1;
              sdata_d = byte_q;
`ifdef SHK_SCCB_ACK_CHECK_EN
              if (i_sccb_sda_i) err_d[ERR_NACK] = 1'b1;
`endif
            end else begin
              bit_d = bit_idx + 1'b1;
              sh_d  = sh_q << 1;
              if (bit_idx == BIT_LAST) sda_t_d = 1'b1;
              else                     sda_o_d = sh_q[WD_SHK_DATA-2];
            end
          end
        endcase
      end
      ST_HOLD: begin
        if (strobe) begin
          accept  = 1'b1;
          state_d = ST_BIT;
          qtr_d   = QTR0;
          bit_d   = '0;
          ready_d = 1'b0;
          sda_o_d = new_byte[WD_SHK_DATA-1];
          sda_t_d = 1'b0;
        end else if (tick) begin
          if (idle_cnt == IW'(NB_STOP_IDLE - 1)) begin
            state_d = ST_STOP;
            qtr_d   = QTR0;
            sda_o_d = 1'b0;
            sda_t_d = 1'b0;
          end else begin
            idle_d = idle_cnt + 1'b1;
          end
        end
      end
      ST_STOP: if (tick) begin
        if (qtr == QTR0) begin
          qtr_d = QTR1;
          scl_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          qtr_d   = QTR0;
          sda_o_d = 1'b1;
          sda_t_d = 1'b1;
          ssync_d = 1'b0;
          saddr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // strobes that cannot be taken are dropped and flagged
    if (strobe && (!s_shk_ready || state == ST_STOP)) err_d[ERR_BUSY] = 1'b1;
    if (accept) begin
      byte_d = new_byte;
      sh_d   = new_byte;
      if (dual) err_d[ERR_DUAL] = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state           <= ST_IDLE;
      qtr             <= QTR0;
      bit_idx         <= '0;
      idle_cnt        <= '0;
      byte_q          <= '0;
      sh_q            <= '0;
      o_sccb_scl      <= 1'b1;
      o_sccb_sda_o    <= 1'b1;
      o_sccb_sda_t    <= 1'b1;
      s_shk_ready     <= 1'b1;
      s_shk_ssync     <= 1'b0;
      s_shk_sdata     <= '0;
      s_shk_saddr     <= '0;
      m_err_shk_info1 <= '0;
    end else begin
      state           <= state_d;
      qtr             <= qtr_d;
      bit_idx         <= bit_d;
      idle_cnt        <= idle_d;
      byte_q          <= byte_d;
      sh_q            <= sh_d;
      o_sccb_scl      <= scl_d;
      o_sccb_sda_o    <= sda_o_d;
      o_sccb_sda_t    <= sda_t_d;
      s_shk_ready     <= ready_d;
      s_shk_ssync     <= ssync_d;
      s_shk_sdata     <= sdata_d;
      s_shk_saddr     <= saddr_d;
      m_err_shk_info1 <= err_d;
    end
  end

endmodule
